// File: rtl/key_led_pkg.sv
// Shared types and constants for the key-driven RGB LED selector.
package key_led_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } state_t;

   localparam logic [2:0] LED_GREEN = 3'b110;
   localparam logic [2:0] LED_RED   = 3'b101;
   localparam logic [2:0] LED_BLUE  = 3'b011;

   function automatic logic [2:0] rotate_led(input logic [2:0] value);
      return {value[1:0], value[2]};
   endfunction

   function automatic logic led_legal(input logic [2:0] value);
      return (value == LED_GREEN) || (value == LED_RED) || (value == LED_BLUE);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability-counter debounce for an active-low key.
// key_state is 1 while pressed; press/release strobe on the cycle the level flips.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 240_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_n,
   output logic key_state,
   output logic press_edge,
   output logic release_edge
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync_0;
   logic            sync_1;
   logic [DB_W-1:0] db_cnt;
   logic            differ;
   logic            flip;

   assign differ       = (~sync_1) != key_state;
   assign flip         = differ && (db_cnt == DB_LAST);
   assign press_edge   = flip && !key_state;
   assign release_edge = flip && key_state;

   // Synchronizer resets to the released level so a held key is re-debounced.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_0    <= 1'b1;
         sync_1    <= 1'b1;
         db_cnt    <= '0;
         key_state <= 1'b0;
      end else begin
         sync_0 <= key_n;
         sync_1 <= sync_0;
         if (!differ) begin
            db_cnt <= '0;
         end else if (flip) begin
            db_cnt    <= '0;
            key_state <= ~key_state;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/key_led_select.sv
// Pushbutton-driven RGB selector: short press rotates G->R->B, long press handling.
// Optional auto-repeat while held is enabled by defining KEY_LED_AUTO_REPEAT_EN.
//
//   state     | meaning
//   IDLE      | key released, waiting for debounced press
//   PRESSED   | key held, counting towards the long-press threshold
//   LONG_HELD | long press reached, waiting for release
module key_led_select
   import key_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 240_000,
   parameter int LONG_PRESS_CYCLES = 24_000_000,
   parameter int REPEAT_CYCLES     = 6_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_n,
   output logic [2:0] led,
   output logic       key_state,
   output logic       short_pulse,
   output logic       long_pulse
);

   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("key_led_select: invalid timing parameters");
   end

   state_t            state;
   state_t            state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              press_edge;
   logic              release_edge;
   logic              rotate;
   logic              load_green;
   logic              short_set;
   logic              long_set;
   logic              hold_clr;
   logic              hold_inc;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_n       (key_n),
      .key_state   (key_state),
      .press_edge  (press_edge),
      .release_edge(release_edge)
   );

`ifdef KEY_LED_AUTO_REPEAT_EN
   localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_clr;
   logic             rep_inc;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rep_cnt <= '0;
      end else if (rep_clr) begin
         rep_cnt <= '0;
      end else if (rep_inc) begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end
`endif

   always_comb begin
      state_nxt  = state;
      rotate     = 1'b0;
      load_green = 1'b0;
      short_set  = 1'b0;
      long_set   = 1'b0;
      hold_clr   = 1'b0;
      hold_inc   = 1'b0;
`ifdef KEY_LED_AUTO_REPEAT_EN
      rep_clr    = 1'b0;
      rep_inc    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (press_edge) begin
               state_nxt = PRESSED;
               hold_clr  = 1'b1;
            end
         end
         PRESSED: begin
            // Release takes priority over a coincident long threshold.
            if (release_edge) begin
               state_nxt = IDLE;
               short_set = 1'b1;
               rotate    = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG_HELD;
               long_set  = 1'b1;
`ifdef KEY_LED_AUTO_REPEAT_EN
               rotate    = 1'b1;
               rep_clr   = 1'b1;
`else
               load_green = 1'b1;
`endif
            end else begin
               hold_inc = 1'b1;
            end
         end
         LONG_HELD: begin
            if (release_edge) begin
               state_nxt = IDLE;
            end
`ifdef KEY_LED_AUTO_REPEAT_EN
            else if (rep_cnt == REP_LAST) begin
               rotate  = 1'b1;
               rep_clr = 1'b1;
            end else begin
               rep_inc = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         led         <= LED_GREEN;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
      end else begin
         state       <= state_nxt;
         short_pulse <= short_set;
         long_pulse  <= long_set;
         if (hold_clr) begin
            hold_cnt <= '0;
         end else if (hold_inc && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
         // A corrupted led value is recovered to green before anything else.
         if (!led_legal(led)) begin
            led <= LED_GREEN;
         end else if (load_green) begin
            led <= LED_GREEN;
         end else if (rotate) begin
            led <= rotate_led(led);
         end
      end
   end

endmodule

// File: tb/tb_key_led_select.sv
// Directed bench for key_led_select with short debounce/long/repeat timings.
module tb_key_led_select;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       key_n;
   logic [2:0] led;
   logic       key_state;
   logic       short_pulse;
   logic       long_pulse;

   int checks = 0;
   int errors = 0;
   int short_cnt = 0;
   int long_cnt = 0;

   key_led_select #(
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(20),
      .REPEAT_CYCLES    (8)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_n      (key_n),
      .led        (led),
      .key_state  (key_state),
      .short_pulse(short_pulse),
      .long_pulse (long_pulse)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      string      name;
      int         mode;
      int         n;
      logic [2:0] exp_led;
      int         exp_short;
      int         exp_long;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic legal(input logic [2:0] l);
      return (l == 3'b110) || (l == 3'b101) || (l == 3'b011);
   endfunction

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (short_pulse) short_cnt++;
         if (long_pulse)  long_cnt++;
         check("pulse_exclusive", {31'd0, short_pulse && long_pulse}, 32'd0);
         check("led_onehot", {31'd0, legal(led)}, 32'd1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic do_press(input int mode, input int n);
      if (mode == 0) begin
         key_n = 1'b0;
         tick(n);
         key_n = 1'b1;
      end else begin
         for (int i = 0; i < n / 2; i++) begin
            key_n = ~key_n;
            tick(2);
         end
         key_n = 1'b1;
      end
      tick(14);
   endtask

   initial begin
      int k;
`ifdef KEY_LED_AUTO_REPEAT_EN
      logic [2:0] el [10] = '{3'b101, 3'b011, 3'b110, 3'b101, 3'b101,
                              3'b101, 3'b101, 3'b011, 3'b110, 3'b101};
`else
      logic [2:0] el [10] = '{3'b101, 3'b011, 3'b110, 3'b101, 3'b110,
                              3'b110, 3'b110, 3'b101, 3'b011, 3'b110};
`endif
      vecs[0] = '{"short1",     0, 10, el[0], 1, 0};
      vecs[1] = '{"short2",     0, 10, el[1], 1, 0};
      vecs[2] = '{"short3",     0, 10, el[2], 1, 0};
      vecs[3] = '{"short4",     0, 10, el[3], 1, 0};
      vecs[4] = '{"long40",     0, 40, el[4], 0, 1};
      vecs[5] = '{"bounce",     1, 20, el[5], 0, 0};
      vecs[6] = '{"too_short3", 0,  3, el[6], 0, 0};
      vecs[7] = '{"min_press4", 0,  4, el[7], 1, 0};
      vecs[8] = '{"tie20",      0, 20, el[8], 1, 0};
      vecs[9] = '{"long21",     0, 21, el[9], 0, 1};

      sys_rst_n = 1'b0;
      key_n     = 1'b1;
      tick(3);
      check("rst_led", {29'd0, led}, 32'h6);
      check("rst_key_state", {31'd0, key_state}, 32'd0);
      check("rst_short", {31'd0, short_pulse}, 32'd0);
      check("rst_long", {31'd0, long_pulse}, 32'd0);
      sys_rst_n = 1'b1;
      tick(2);

      // Clean press: key_state rises exactly 6 cycles after the key edge.
      short_cnt = 0;
      long_cnt  = 0;
      key_n = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         if (i == 5) check("latency_before", {31'd0, key_state}, 32'd0);
         if (i == 6) check("latency_at", {31'd0, key_state}, 32'd1);
      end
      tick(4);
      key_n = 1'b1;
      tick(14);
      check("clean_led", {29'd0, led}, 32'h5);
      check("clean_short", short_cnt, 1);
      check("clean_long", long_cnt, 0);

      sys_rst_n = 1'b0;
      #1;
      check("rst2_led", {29'd0, led}, 32'h6);
      tick(2);
      sys_rst_n = 1'b1;
      tick(2);

      for (int v = 0; v < 10; v++) begin
         short_cnt = 0;
         long_cnt  = 0;
         do_press(vecs[v].mode, vecs[v].n);
         check({vecs[v].name, "_led"}, {29'd0, led}, {29'd0, vecs[v].exp_led});
         check({vecs[v].name, "_short"}, short_cnt, vecs[v].exp_short);
         check({vecs[v].name, "_long"}, long_cnt, vecs[v].exp_long);
      end

      // Long pulse timing relative to the debounced press.
      short_cnt = 0;
      long_cnt  = 0;
      key_n = 1'b0;
      k = 0;
      while (!key_state && k < 20) begin
         tick(1);
         k++;
      end
      check("long_press_seen", {31'd0, key_state}, 32'd1);
      k = 0;
      while (!long_pulse && k < 40) begin
         tick(1);
         k++;
      end
      check("long_delay", k, 20);
      tick(5);
      key_n = 1'b1;
      tick(14);
      check("long_once", long_cnt, 1);
      check("long_no_short", short_cnt, 0);

      // Reset in the middle of a hold abandons the press.
      do_press(0, 10);
      short_cnt = 0;
      long_cnt  = 0;
      key_n = 1'b0;
      tick(15);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_led", {29'd0, led}, 32'h6);
      check("midrst_key_state", {31'd0, key_state}, 32'd0);
      check("midrst_pulses", {30'd0, short_pulse, long_pulse}, 32'd0);
      tick(3);
      sys_rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         if (i == 5) check("redetect_before", {31'd0, key_state}, 32'd0);
         if (i == 6) check("redetect_at", {31'd0, key_state}, 32'd1);
      end
      check("midrst_no_short", short_cnt, 0);
      check("midrst_no_long", long_cnt, 0);
      key_n = 1'b1;
      tick(14);
      check("after_rst_led", {29'd0, led}, 32'h5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
